// File: rtl/mac_accumulator_4bit_if.sv
// mac_accumulator_4bit_if: operand and result handshakes of the 4-bit MAC.
// The master side is the operand source plus result sink; the slave side is the MAC.
interface mac_accumulator_4bit_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );
endinterface

// File: rtl/mac_accumulator_4bit.sv
// mac_accumulator_4bit: sums N_TERMS products of 4-bit operand pairs and
// hands out the dot product over a valid/ready handshake.
// Optional feature: define MAC_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on carry-out instead of wrapping.

// Combinational 4-bit unsigned array multiplier: one shifted partial-product row per multiplier bit.
module mult_array_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_row [0:4];

  assign w_row[0] = 8'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign w_row[gi+1] = w_row[gi] + ({4'd0, i_a & {4{i_b[gi]}}} << gi);
  end

  assign o_p = w_row[4];
endmodule

module mac_accumulator_4bit #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_accumulator_4bit_if.slave bus
);
  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_cnt;
  logic [7:0]       r_prod_q;
  logic             r_prod_v;
  logic             r_prod_last;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_out_fire;
  logic [7:0]       w_prod;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;

  mult_array_4bit u_mult (
    .i_a (bus.a),
    .i_b (bus.b),
    .o_p (w_prod)
  );

  // Ready is gated by rst so nothing is accepted while reset is held.
  assign bus.in_ready  = (r_state == S_ACCUM) && !rst;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.acc_out   = r_acc;
  assign bus.overflow  = r_ovf;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_last     = (r_cnt == LAST_IDX);
  assign w_out_fire = bus.out_valid && bus.out_ready;

  // One extra bit on the add so the carry out of the top accumulator bit is visible.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, r_prod_q};

`ifdef MAC_SATURATE_EN
  // Once clamped, any further nonzero product carries again, so the value stays pinned.
  assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // Product stage and term counter: capture a*b on every accept and tag the last term.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_q    <= 8'd0;
      r_prod_v    <= 1'b0;
      r_prod_last <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_prod_v    <= w_accept;
      r_prod_last <= w_accept && w_last;
      if (w_accept) begin
        r_prod_q <= w_prod;
        r_cnt    <= w_last ? 8'd0 : r_cnt + 8'd1;
      end
    end
  end

  // Accumulator with sticky overflow; both clear when the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_out_fire) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_prod_v) begin
      r_acc <= w_acc_next;
      if (w_sum[ACC_W]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: accept terms, drain the final product, then hold the result until taken.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: if (w_accept && w_last) w_state_next = S_DRAIN;
      S_DRAIN: if (r_prod_last)        w_state_next = S_HOLD;
      S_HOLD:  if (w_out_fire)         w_state_next = S_ACCUM;
      default:                         w_state_next = S_ACCUM;
    endcase
  end
endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// tb_mac_accumulator_4bit: directed checks of the MAC on four parameterisations.
module tb_mac_accumulator_4bit;
  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_mis;

  mac_accumulator_4bit_if #(.ACC_W(12)) if4 ();
  mac_accumulator_4bit_if #(.ACC_W(12)) if8 ();
  mac_accumulator_4bit_if #(.ACC_W(9))  if9 ();
  mac_accumulator_4bit_if #(.ACC_W(12)) if1 ();

  mac_accumulator_4bit #(.N_TERMS(4), .ACC_W(12)) u4 (.clk(clk), .rst(rst), .bus(if4));
  mac_accumulator_4bit #(.N_TERMS(8), .ACC_W(12)) u8 (.clk(clk), .rst(rst), .bus(if8));
  mac_accumulator_4bit #(.N_TERMS(4), .ACC_W(9))  u9 (.clk(clk), .rst(rst), .bus(if9));
  mac_accumulator_4bit #(.N_TERMS(1), .ACC_W(12)) u1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       iv;
    logic [3:0] a;
    logic [3:0] b;
    logic       ordy;
    logic       ir;
    logic       ov;
    int         acc;
    logic       of;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(input logic iv, input logic [3:0] a, input logic [3:0] b,
                              input logic ordy, input logic ir, input logic ov,
                              input int acc, input logic of);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.acc = acc; v.of = of;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    bit found;
    int accepts;
    int acc_cyc;
    int exp9;
    logic [3:0] pa [2];
    logic [3:0] pb [2];
    int         pexp [2];

    n_vec = 0;
    n_mis = 0;

    // Cycle table for N_TERMS=4: first result back-to-back, then a
    // backpressured result, then the first term of a fresh sum.
    vt[0]  = mk(1, 3,  5,  1, 1, 0, 0,   0);
    vt[1]  = mk(1, 15, 15, 1, 1, 0, 0,   0);
    vt[2]  = mk(1, 0,  9,  1, 1, 0, 15,  0);
    vt[3]  = mk(1, 7,  2,  1, 1, 0, 240, 0);
    vt[4]  = mk(0, 0,  0,  1, 0, 0, 240, 0);
    vt[5]  = mk(0, 0,  0,  1, 0, 1, 254, 0);
    vt[6]  = mk(1, 1,  2,  0, 1, 0, 0,   0);
    vt[7]  = mk(1, 2,  2,  0, 1, 0, 0,   0);
    vt[8]  = mk(1, 3,  3,  0, 1, 0, 2,   0);
    vt[9]  = mk(1, 4,  4,  0, 1, 0, 6,   0);
    vt[10] = mk(1, 9,  9,  0, 0, 0, 15,  0);
    for (int i = 11; i <= 16; i++) vt[i] = mk(1, 9, 9, 0, 0, 1, 31, 0);
    vt[17] = mk(1, 9,  9,  1, 0, 1, 31,  0);
    vt[18] = mk(1, 9,  9,  0, 1, 0, 0,   0);
    vt[19] = mk(0, 0,  0,  0, 1, 0, 0,   0);
    vt[20] = mk(0, 0,  0,  0, 1, 0, 81,  0);

    rst = 1'b1;
    if4.in_valid = 0; if4.a = 0; if4.b = 0; if4.out_ready = 0;
    if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.out_ready = 0;
    if9.in_valid = 0; if9.a = 0; if9.b = 0; if9.out_ready = 0;
    if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.out_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", int'(if4.in_ready), 0);
    chk("rst_out_valid", int'(if4.out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Row 0 is the first cycle after reset, so it also checks reset values.
    for (int i = 0; i < 21; i++) begin
      if4.in_valid  = vt[i].iv;
      if4.a         = vt[i].a;
      if4.b         = vt[i].b;
      if4.out_ready = vt[i].ordy;
      @(negedge clk);
      $display("vec %0d: iv=%0d a=%0d b=%0d ordy=%0d -> ir=%0d ov=%0d acc=%0d of=%0d",
               i, vt[i].iv, vt[i].a, vt[i].b, vt[i].ordy,
               if4.in_ready, if4.out_valid, if4.acc_out, if4.overflow);
      chk($sformatf("v%0d_in_ready", i),  int'(if4.in_ready),  int'(vt[i].ir));
      chk($sformatf("v%0d_out_valid", i), int'(if4.out_valid), int'(vt[i].ov));
      chk($sformatf("v%0d_acc_out", i),   int'(if4.acc_out),   vt[i].acc);
      chk($sformatf("v%0d_overflow", i),  int'(if4.overflow),  int'(vt[i].of));
      @(posedge clk);
      #1;
    end

    // Reset after two of four terms (81 already in, 25 in flight).
    if4.in_valid = 1; if4.a = 5; if4.b = 5;
    @(negedge clk);
    chk("mid_accept", int'(if4.in_ready), 1);
    @(posedge clk);
    #1 if4.in_valid = 0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(if4.in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("after reset: acc=%0d ov=%0d of=%0d ir=%0d",
             if4.acc_out, if4.out_valid, if4.overflow, if4.in_ready);
    chk("post_rst_acc", int'(if4.acc_out), 0);
    chk("post_rst_out_valid", int'(if4.out_valid), 0);
    chk("post_rst_overflow", int'(if4.overflow), 0);
    chk("post_rst_in_ready", int'(if4.in_ready), 1);
    @(posedge clk);
    #1 if4.in_valid = 1; if4.a = 1; if4.b = 1;
    repeat (4) @(posedge clk);
    #1 if4.in_valid = 0; if4.out_ready = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (if4.out_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("post_rst_timeout", int'(found), 1);
    $display("post-reset result: acc=%0d", if4.acc_out);
    chk("post_rst_sum", int'(if4.acc_out), 4);
    @(posedge clk);
    #1 if4.out_ready = 0;

    // Defaults: eight (15,15) with random in_valid gaps.
    if8.a = 15; if8.b = 15;
    accepts = 0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if8.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (if8.in_valid && if8.in_ready) accepts++;
      if (if8.out_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("d8_timeout", int'(found), 1);
    $display("defaults result: acc=%0d of=%0d accepts=%0d", if8.acc_out, if8.overflow, accepts);
    chk("d8_sum", int'(if8.acc_out), 1800);
    chk("d8_overflow", int'(if8.overflow), 0);
    chk("d8_accepts", accepts, 8);
    @(posedge clk);
    #1 if8.in_valid = 0; if8.out_ready = 1;
    @(posedge clk);
    #1 if8.out_ready = 0;
    @(negedge clk);
    chk("d8_after_out_valid", int'(if8.out_valid), 0);
    chk("d8_after_acc", int'(if8.acc_out), 0);

    // ACC_W=9: four (15,15) = 900 exceeds 511.
`ifdef MAC_SATURATE_EN
    exp9 = 511;
`else
    exp9 = 388;
`endif
    @(posedge clk);
    #1 if9.in_valid = 1; if9.a = 15; if9.b = 15;
    repeat (4) @(posedge clk);
    #1 if9.in_valid = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (if9.out_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("w9_timeout", int'(found), 1);
    $display("acc_w9 result: acc=%0d of=%0d", if9.acc_out, if9.overflow);
    chk("w9_sum", int'(if9.acc_out), exp9);
    chk("w9_overflow", int'(if9.overflow), 1);
    @(posedge clk);
    #1 if9.out_ready = 1;
    @(posedge clk);
    #1 if9.out_ready = 0;
    @(negedge clk);
    chk("w9_overflow_cleared", int'(if9.overflow), 0);
    chk("w9_acc_cleared", int'(if9.acc_out), 0);

    // N_TERMS=1: every accept is a complete result two cycles later.
    pa[0] = 2; pb[0] = 3; pexp[0] = 6;
    pa[1] = 4; pb[1] = 4; pexp[1] = 16;
    @(posedge clk);
    #1 if1.out_ready = 1;
    for (int p = 0; p < 2; p++) begin
      if1.in_valid = 1; if1.a = pa[p]; if1.b = pb[p];
      found = 0;
      acc_cyc = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        @(negedge clk);
        if (if1.in_ready) begin found = 1; acc_cyc = cyc; end
        @(posedge clk);
        #1;
      end
      if1.in_valid = 0;
      chk($sformatf("n1_p%0d_accept_timeout", p), int'(found), 1);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        @(negedge clk);
        if (if1.out_valid) found = 1;
        else begin @(posedge clk); #1; end
      end
      chk($sformatf("n1_p%0d_result_timeout", p), int'(found), 1);
      $display("n1 pair %0d: acc=%0d latency=%0d", p, if1.acc_out, cyc - acc_cyc);
      chk($sformatf("n1_p%0d_latency", p), cyc - acc_cyc, 2);
      chk($sformatf("n1_p%0d_sum", p), int'(if1.acc_out), pexp[p]);
      @(posedge clk);
      #1;
    end
    if1.out_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
